// File: rtl/temp_sampler.sv
// -----------------------------------------------------------------------------
// temp_sampler
//
// Purpose:
//   Collects temperature samples from two sensors sharing a single input port.
//   - Greenhouse samples go through a 4-sample moving average.
//   - Outside samples are held as-is.
//   - A flag reports whether outside is warmer than the greenhouse. The flag
//     uses a hysteresis band so it does not chatter near equality.
//   - A stale detector watches the greenhouse sensor.
//   - Rejected (-128) samples are counted.
//
// Parameters:
//   STALE_LIMIT  cycles without an accepted greenhouse sample before stale (1..65535)
//   HYST         hysteresis band in degrees for the warmer flag (0..15)
//
// Ports:
//   clk                     in   clock, all state changes on the rising edge
//   rst                     in   synchronous active-high reset
//   in_valid                in   a sample is present this cycle
//   in_sel                  in   sample source: 0 = greenhouse, 1 = outside
//   in_temp        [7:0]    in   signed sample in degrees
//   greenhouse_temp[7:0]    out  signed 4-sample average of greenhouse samples
//   outside_temp   [7:0]    out  signed last accepted outside sample
//   temp_g_greenhouse_temp  out  outside warmer than greenhouse (hysteresis)
//   out_valid               out  average and warmer flag are trustworthy
//   stale                   out  greenhouse sensor silent for STALE_LIMIT cycles
//   err_count      [7:0]    out  rejected samples, saturating at 255
//
// Handshake:
//   in_valid is a one-sided valid with no ready. The block always consumes
//   the sample on the rising edge where in_valid=1. The sample is accepted
//   unless in_temp is -128 (8'h80). A -128 sample is only counted in
//   err_count and leaves every other piece of state alone.
// -----------------------------------------------------------------------------
module temp_sampler #(
    parameter logic [15:0] STALE_LIMIT = 16'd1000,
    parameter logic [3:0]  HYST        = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sel,
    input  logic [7:0] in_temp,
    output logic [7:0] greenhouse_temp,
    output logic [7:0] outside_temp,
    output logic       temp_g_greenhouse_temp,
    output logic       out_valid,
    output logic       stale,
    output logic [7:0] err_count
);

    localparam logic [7:0] BAD_SAMPLE = 8'h80;

    // Storage
    logic signed [7:0] gh_buf [4];   // [0] newest, [3] oldest
    logic signed [7:0] avg_q;
    logic signed [7:0] outside_q;
    logic        [2:0] fill_cnt;
    logic              outside_seen;
    logic              gh_acc_q;     // greenhouse sample accepted on the previous edge
    logic              flag_q;
    logic       [15:0] stale_cnt;
    logic        [7:0] err_q;

    // Combinational helpers
    logic              sample_ok;
    logic              reject;
    logic              gh_accept;
    logic              out_accept;
    logic signed [9:0] buf_sum;
    logic signed [8:0] diff;
    logic signed [8:0] hyst_pos;
    logic signed [8:0] hyst_neg;
    logic              flag_next;

    assign sample_ok  = (in_temp != BAD_SAMPLE);
    assign reject     = in_valid && !sample_ok;
    assign gh_accept  = in_valid && sample_ok && !in_sel;
    assign out_accept = in_valid && sample_ok && in_sel;

    // A 10-bit sum holds four 8-bit signed values without overflow.
    assign buf_sum = {{2{gh_buf[0][7]}}, gh_buf[0]}
                   + {{2{gh_buf[1][7]}}, gh_buf[1]}
                   + {{2{gh_buf[2][7]}}, gh_buf[2]}
                   + {{2{gh_buf[3][7]}}, gh_buf[3]};

    // A 9-bit difference covers -255..+255, so it cannot overflow.
    assign diff     = {outside_q[7], outside_q} - {avg_q[7], avg_q};
    assign hyst_pos = {5'd0, HYST};
    assign hyst_neg = -hyst_pos;

    assign stale = (stale_cnt == STALE_LIMIT);

    // Suppress out_valid on the cycle right after a greenhouse sample is
    // accepted. On that cycle the average register still shows the old buffer.
    assign out_valid = (fill_cnt == 3'd4) && outside_seen && !stale && !gh_acc_q;

    // Set wins over clear, so the flag sets when HYST=0 and diff=0.
    always_comb begin
        flag_next = flag_q;
        if (!out_valid) begin
            flag_next = 1'b0;
        end else if (diff >= hyst_pos) begin
            flag_next = 1'b1;
        end else if (diff <= hyst_neg) begin
            flag_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                gh_buf[i] <= '0;
            end
            avg_q        <= '0;
            outside_q    <= '0;
            fill_cnt     <= '0;
            outside_seen <= 1'b0;
            gh_acc_q     <= 1'b0;
            flag_q       <= 1'b0;
            stale_cnt    <= '0;
            err_q        <= '0;
        end else begin
            // Arithmetic shift floors toward negative infinity.
            avg_q    <= 8'(buf_sum >>> 2);
            flag_q   <= flag_next;
            gh_acc_q <= gh_accept;

            if (gh_accept) begin
                gh_buf[3] <= gh_buf[2];
                gh_buf[2] <= gh_buf[1];
                gh_buf[1] <= gh_buf[0];
                gh_buf[0] <= in_temp;
                if (fill_cnt != 3'd4) begin
                    fill_cnt <= fill_cnt + 3'd1;
                end
                stale_cnt <= '0;
            end else if (stale_cnt != STALE_LIMIT) begin
                stale_cnt <= stale_cnt + 16'd1;
            end

            if (out_accept) begin
                outside_q    <= in_temp;
                outside_seen <= 1'b1;
            end

            if (reject && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign greenhouse_temp = avg_q;
    assign outside_temp    = outside_q;
    // Also gate the flag directly, so it reads 0 on the same cycle out_valid drops.
    assign temp_g_greenhouse_temp = flag_q && out_valid;
    assign err_count = err_q;

endmodule

// File: tb/tb_temp_sampler.sv
// -----------------------------------------------------------------------------
// tb_temp_sampler
//
// Bench for temp_sampler, built with STALE_LIMIT=10 and HYST=2.
//
// The reference model is written in plain integer arithmetic:
//   - a list of the last four greenhouse readings,
//   - a floor-divided mean,
//   - min() saturation for the counters.
// Each directed scenario and the random run compare every output after every
// edge. The scenarios also carry spot checks with hand-derived constants.
// -----------------------------------------------------------------------------
module tb_temp_sampler;

    localparam int LIMIT = 10;
    localparam int H     = 2;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sel;
    logic [7:0] in_temp;
    logic [7:0] greenhouse_temp;
    logic [7:0] outside_temp;
    logic       temp_g_greenhouse_temp;
    logic       out_valid;
    logic       stale;
    logic [7:0] err_count;

    int n_vec  = 0;
    int n_fail = 0;

    temp_sampler #(
        .STALE_LIMIT(16'd10),
        .HYST       (4'd2)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .in_valid              (in_valid),
        .in_sel                (in_sel),
        .in_temp               (in_temp),
        .greenhouse_temp       (greenhouse_temp),
        .outside_temp          (outside_temp),
        .temp_g_greenhouse_temp(temp_g_greenhouse_temp),
        .out_valid             (out_valid),
        .stale                 (stale),
        .err_count             (err_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_hist[4];      // last four greenhouse readings, [0] newest
    int m_avg;
    int m_out;
    int m_fill;
    int m_stale_cnt;
    int m_err;
    bit m_seen;
    bit m_prev_gh;
    bit m_flag;

    function automatic int floor_div4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    function automatic bit m_stale();
        return m_stale_cnt == LIMIT;
    endfunction

    function automatic bit m_valid();
        return (m_fill == 4) && m_seen && !m_stale() && !m_prev_gh;
    endfunction

    function automatic logic [26:0] model_vec();
        logic [7:0] a;
        logic [7:0] o;
        logic [7:0] e;
        a = m_avg[7:0];
        o = m_out[7:0];
        e = m_err[7:0];
        return {a, o, m_flag && m_valid(), m_valid(), m_stale(), e};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {greenhouse_temp, outside_temp, temp_g_greenhouse_temp,
                out_valid, stale, err_count};
    endfunction

    task automatic model_edge(input bit r, input bit v, input bit s, input int t);
        int  diff;
        bit  nf;
        int  sum;
        bit  acc;
        if (r) begin
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
            m_avg = 0; m_out = 0; m_fill = 0; m_stale_cnt = 0; m_err = 0;
            m_seen = 0; m_prev_gh = 0; m_flag = 0;
            return;
        end
        diff = m_out - m_avg;
        if (!m_valid())     nf = 1'b0;
        else if (diff >= H) nf = 1'b1;
        else if (diff <= -H) nf = 1'b0;
        else                nf = m_flag;
        sum = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
        m_avg  = floor_div4(sum);
        m_flag = nf;
        acc = v && (t != -128);
        if (v && (t == -128) && (m_err < 255)) m_err++;
        if (acc && !s) begin
            m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0]; m_hist[0] = t;
            m_fill = (m_fill < 4) ? m_fill + 1 : 4;
            m_stale_cnt = 0;
        end else begin
            m_stale_cnt = (m_stale_cnt < LIMIT) ? m_stale_cnt + 1 : LIMIT;
        end
        if (acc && s) begin
            m_out  = t;
            m_seen = 1'b1;
        end
        m_prev_gh = acc && !s;
    endtask

    // ---------------- driver ----------------
    // Drive inputs, let one rising edge pass, update the model, then settle.
    task automatic drive(input bit r, input bit v, input bit s, input int t);
        rst      = r;
        in_valid = v;
        in_sel   = s;
        in_temp  = t[7:0];
        @(posedge clk);
        model_edge(r, v, s, t);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 33);
        n_vec++;
        if (dut_vec() !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_zero: got %h expected %h", dut_vec(), 27'd0);
        end
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_fill();
        int seq_s[5] = '{1, 0, 0, 0, 0};
        int seq_t[5] = '{30, 20, 20, 20, 20};
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, seq_s[i][0], seq_t[i]);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL fill_cycle%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_valid_early: got %b expected 0", out_valid);
        end
        drive(0, 0, 0, 0);
        n_vec++;
        if ({out_valid, greenhouse_temp, temp_g_greenhouse_temp} !== {1'b1, 8'd20, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_valid: got v=%b avg=%0d flag=%b expected v=1 avg=20 flag=0",
                     out_valid, greenhouse_temp, temp_g_greenhouse_temp);
        end
        drive(0, 0, 0, 0);
        n_vec++;
        if (temp_g_greenhouse_temp !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_flag: got %b expected 1", temp_g_greenhouse_temp);
        end
    endtask

    task automatic test_rounding();
        int seq_t[4] = '{-3, -3, -3, -2};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, seq_t[i]);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL round_cycle%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        drive(0, 0, 0, 0);
        n_vec++;
        if (greenhouse_temp !== 8'hFD) begin
            n_fail++;
            $display("FAIL round_neg: got %h expected fd", greenhouse_temp);
        end
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 127);
        drive(0, 0, 0, 0);
        n_vec++;
        if (greenhouse_temp !== 8'h7F) begin
            n_fail++;
            $display("FAIL round_max: got %h expected 7f", greenhouse_temp);
        end
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL round_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_hysteresis();
        int  outs[4] = '{22, 21, 18, 19};
        bit  want[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 20);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, outs[i]);
            drive(0, 0, 0, 0);
            n_vec++;
            if (temp_g_greenhouse_temp !== want[i]) begin
                n_fail++;
                $display("FAIL hyst_out%0d: got %b expected %b", outs[i],
                         temp_g_greenhouse_temp, want[i]);
            end
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL hyst_model%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_reject();
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 8);
        drive(0, 1, 1, 10);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, -128);
        drive(0, 0, 0, 0);
        n_vec++;
        if (greenhouse_temp !== 8'd8) begin
            n_fail++;
            $display("FAIL reject_buf: got %0d expected 8", greenhouse_temp);
        end
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL reject_model: got %h expected %h", dut_vec(), model_vec());
        end
        for (int i = 0; i < 256; i++) drive(0, 1, i[0], -128);
        n_vec++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL reject_sat: got %0d expected 255", err_count);
        end
    endtask

    task automatic test_stale();
        drive(0, 1, 1, 10);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 5);
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 0);
        n_vec++;
        if ({stale, out_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL stale_early: got stale/valid %b expected 01", {stale, out_valid});
        end
        drive(0, 0, 0, 0);
        n_vec++;
        if ({stale, out_valid, temp_g_greenhouse_temp} !== 3'b100) begin
            n_fail++;
            $display("FAIL stale_set: got %b expected 100",
                     {stale, out_valid, temp_g_greenhouse_temp});
        end
        drive(0, 1, 0, 5);
        n_vec++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_clear: got %b expected 0", stale);
        end
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL stale_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 40);
        drive(0, 1, 1, 50);
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 60);
        n_vec++;
        if (dut_vec() !== 27'd0) begin
            n_fail++;
            $display("FAIL rstmid_zero: got %h expected %h", dut_vec(), 27'd0);
        end
        drive(0, 1, 1, 50);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 12);
        drive(0, 0, 0, 0);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_partial: got %b expected 0", out_valid);
        end
        drive(0, 1, 0, 16);
        drive(0, 0, 0, 0);
        n_vec++;
        if ({out_valid, greenhouse_temp} !== {1'b1, 8'd13}) begin
            n_fail++;
            $display("FAIL rstmid_refill: got v=%b avg=%0d expected v=1 avg=13",
                     out_valid, greenhouse_temp);
        end
    endtask

    task automatic test_random();
        int vprob;
        int t;
        bit r;
        bit v;
        bit s;
        vprob = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0:       vprob = 5;
                    1:       vprob = 50;
                    default: vprob = 95;
                endcase
            end
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 99) < vprob);
            s = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 15) == 0) t = -128;
            else                            t = int'($urandom_range(0, 255)) - 128;
            drive(r, v, s, t);
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_temp  = 8'd0;
        test_reset();
        test_fill();
        test_rounding();
        test_hysteresis();
        test_reject();
        test_stale();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/temp_sampler.md
TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 Parameter STALE_LIMIT, default 16'd1000, cycles without an accepted greenhouse sample before the stale flag asserts; legal range 1..65535.
REQ-002 Parameter HYST, default 4'd2, hysteresis band in degrees for the outside-warmer flag; legal range 0..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  a sensor sample is present this cycle.
REQ-006 The block SHALL have port in_sel  input  1  sample source: 0 = greenhouse sensor, 1 = outside sensor.
REQ-007 The block SHALL have port in_temp  input  8  signed two's-complement sample in degrees.
REQ-008 The block SHALL have port greenhouse_temp  output  8  signed 4-sample moving average of greenhouse samples.
REQ-009 The block SHALL have port outside_temp  output  8  signed, last accepted outside sample.
REQ-010 The block SHALL have port temp_g_greenhouse_temp  output  1  outside is warmer than greenhouse, with hysteresis.
REQ-011 The block SHALL have port out_valid  output  1  greenhouse_temp and temp_g_greenhouse_temp are trustworthy.
REQ-012 The block SHALL have port stale  output  1  greenhouse sensor silent for STALE_LIMIT cycles.
REQ-013 The block SHALL have port err_count  output  8  count of rejected samples, saturating at 255.

Function
REQ-014 A sample SHALL be accepted on a rising edge when in_valid=1 and in_temp != 8'h80 (-128); there is no backpressure.
REQ-015 A sample with in_valid=1 and in_temp=8'h80 SHALL be rejected, leave all other state untouched, and increment err_count (saturating at 255, no wrap).
REQ-016 Greenhouse samples SHALL enter a 4-entry shift buffer, newest in, oldest discarded.
REQ-017 greenhouse_temp SHALL equal (sum of 4 buffer entries, 10-bit signed) arithmetic-shifted right by 2 (floor toward negative infinity), registered one cycle after the buffer update: a sample accepted at edge N is reflected after edge N+1.
REQ-018 An accepted outside sample SHALL update outside_temp at the same edge (latency 1 from in_valid).
REQ-019 A fill counter SHALL count accepted greenhouse samples, saturating at 4.
REQ-020 A flag SHALL record that at least one outside sample has been accepted since reset.
REQ-021 out_valid SHALL be 1 exactly when the fill counter = 4, the outside flag = 1, stale = 0, and the average register reflects the current buffer, i.e. no greenhouse sample was accepted on the previous edge.
REQ-022 The stale counter SHALL clear on every accepted greenhouse sample, otherwise increment, saturating at STALE_LIMIT.
REQ-023 stale SHALL be 1 while the stale counter = STALE_LIMIT; it clears on the edge that accepts the next greenhouse sample.
REQ-024 Every cycle, diff = outside_temp - greenhouse_temp SHALL be computed at 9-bit signed width, with no overflow.
REQ-025 temp_g_greenhouse_temp SHALL be set when diff >= HYST, cleared when diff <= -HYST, and held otherwise; set has priority when both conditions hold (HYST=0, diff=0). It is registered with 1-cycle latency.
REQ-026 temp_g_greenhouse_temp SHALL be forced to 0 while out_valid=0.

Reset
REQ-027 When rst=1 at an edge, rst SHALL override in_valid, and the following SHALL clear to 0: buffer, greenhouse_temp, outside_temp, fill counter, outside flag, stale counter, stale, err_count, temp_g_greenhouse_temp, out_valid.
REQ-028 A reset asserted mid-operation SHALL discard all history; refill starts from zero after rst deasserts.

Verification
REQ-029 Fill: after reset, send outside 30, then greenhouse 20, 20, 20, 20 on consecutive cycles -> out_valid=1 two edges after the last sample, greenhouse_temp=20, temp_g_greenhouse_temp=1 one cycle later (diff 10 >= 2).
REQ-030 Rounding: greenhouse -3, -3, -3, -2 -> sum -11, greenhouse_temp=-3; greenhouse 127 x4 -> 127, with no overflow.
REQ-031 Hysteresis with HYST=2 and greenhouse 20: outside 22 -> flag 1; outside 21 -> flag holds 1; outside 18 -> flag 0; outside 19 -> flag holds 0.
REQ-032 Rejection: greenhouse 8'h80 -> buffer unchanged, err_count +1; 256 rejections -> err_count stays 255.
REQ-033 Stale with STALE_LIMIT=10: no greenhouse sample for 10 cycles -> stale=1, out_valid=0, flag=0; the next greenhouse sample clears stale.
REQ-034 Reset mid-stream: rst asserted together with in_valid=1 after a full buffer -> all outputs 0 next cycle, sample ignored, out_valid=0 until 4 new greenhouse samples and 1 outside sample arrive.
